pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 108 ++++++++++
 tb/tb_pipe_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - STAGES-deep chunked ripple adder/subtractor with skewed operands
// and de-skewed results, so all N result bits emerge aligned.
module pipe_adder #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid
);
  localparam int W = N / STAGES;

  // Element k is what stage k consumes: operands, partial result, carry, valid.
  logic [N-1:0] a_in [STAGES];
  logic [N-1:0] b_in [STAGES];
  logic [N-1:0] s_in [STAGES];
  logic         c_in [STAGES];
  logic         v_in [STAGES];

  assign a_in[0] = a;
  assign b_in[0] = sub ? ~b : b;
  assign s_in[0] = '0;
  assign c_in[0] = sub ? 1'b1 : cin;
  assign v_in[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W:0]   chunk;
    logic [N-1:0] s_d;

    always_comb begin
      chunk = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]} + {{W{1'b0}}, c_in[k]};
      s_d = s_in[k];
      s_d[k*W +: W] = chunk[W-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      logic [N-1:0] a_d, a_q, b_d, b_q, s_q;
      logic         c_d, c_q, v_d, v_q;

      always_comb begin
        a_d = a_in[k];
        b_d = b_in[k];
        c_d = chunk[W];
        v_d = v_in[k];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= c_d;
          v_q <= v_d;
        end
      end

      assign a_in[k+1] = a_q;
      assign b_in[k+1] = b_q;
      assign s_in[k+1] = s_q;
      assign c_in[k+1] = c_q;
      assign v_in[k+1] = v_q;
    end else begin : g_last
      logic [N-1:0] s_q;
      logic         cout_d, cout_q, ovf_d, ovf_q, valid_d, valid_q;

      // Signed overflow: both operands share a sign the result does not.
      always_comb begin
        cout_d  = chunk[W];
        ovf_d   = (a_in[k][N-1] == b_in[k][N-1]) && (s_d[N-1] != a_in[k][N-1]);
        valid_d = v_in[k];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q     <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else if (en) begin
          s_q     <= s_d;
          cout_q  <= cout_d;
          ovf_q   <= ovf_d;
          valid_q <= valid_d;
        end
      end

      assign s         = s_q;
      assign cout      = cout_q;
      assign ovf       = ovf_q;
      assign out_valid = valid_q;
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - four pipe_adder configurations against an arithmetic model
// of enabled-cycle transaction history, plus literal expectations.
module tb_pipe_adder;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  s1, s2, s8;
  logic [15:0] s16;
  logic        co1, co2, co8, co16, ov1, ov2, ov8, ov16, v1, v2, v8, v16;
  int total = 0, bad = 0;

  pipe_adder #(.N(8), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sub(sub), .s(s2), .cout(co2), .ovf(ov2), .out_valid(v2));
  pipe_adder #(.N(8), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sub(sub), .s(s1), .cout(co1), .ovf(ov1), .out_valid(v1));
  pipe_adder #(.N(8), .STAGES(8)) dut8 (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sub(sub), .s(s8), .cout(co8), .ovf(ov8), .out_valid(v8));
  pipe_adder #(.N(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a16), .b(b16), .cin(cin), .sub(sub), .s(s16), .cout(co16), .ovf(ov16), .out_valid(v16));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        ci, sb;
  } ent_t;
  ent_t hist [8];

  // hist[i] is the transaction sampled i+1 enabled edges ago.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
    end else if (en) begin
      for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= '{in_valid, a, b, a16, b16, cin, sub};
    end
  end

  function automatic logic [17:0] model(input int n, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    longint m, ux, uy, sx, sy, r, res;
    logic co, ov;
    m  = longint'(1) << n;
    ux = longint'(x) % m;
    uy = longint'(y) % m;
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    if (sb) begin
      res = (ux - uy + m) % m;
      co  = (ux >= uy);
      r   = sx - sy;
    end else begin
      res = (ux + uy + longint'(ci)) % m;
      co  = (ux + uy + longint'(ci)) >= m;
      r   = sx + sy + longint'(ci);
    end
    ov = (r >= m / 2) || (r < -(m / 2));
    return {ov, co, res[15:0]};
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string nm, input int st, input int n, input logic v,
                         input logic [15:0] sv, input logic co, input logic ov);
    ent_t e;
    logic [17:0] x;
    e = hist[st-1];
    x = (n == 16) ? model(n, e.a16, e.b16, e.ci, e.sb)
                  : model(n, {8'h00, e.a8}, {8'h00, e.b8}, e.ci, e.sb);
    check({nm, " valid"}, v, e.v);
    if (rst) begin
      check({nm, " rst s"}, sv, 0);
      check({nm, " rst cout"}, co, 0);
      check({nm, " rst ovf"}, ov, 0);
    end else if (e.v) begin
      check({nm, " s"}, sv, x[15:0]);
      check({nm, " cout"}, co, x[16]);
      check({nm, " ovf"}, ov, x[17]);
    end
  endtask

  always @(negedge clk) begin
    cmp_dut("n8s2", 2, 8, v2, {8'h00, s2}, co2, ov2);
    cmp_dut("n8s1", 1, 8, v1, {8'h00, s1}, co1, ov1);
    cmp_dut("n8s8", 8, 8, v8, {8'h00, s8}, co8, ov8);
    cmp_dut("n16s4", 4, 16, v16, s16, co16, ov16);
  end

  task automatic drive(input logic e, input logic v, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic sb);
    en = e; in_valid = v; a = x; b = y; cin = c; sub = sb;
    a16 = {x, y}; b16 = {y, x};
    @(posedge clk);
    #1;
  endtask

  logic [7:0] va [4] = '{8'd200, 8'd127, 8'd20, 8'd30};
  logic [7:0] vb [4] = '{8'd250, 8'd1, 8'd30, 8'd1};
  logic       vsb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] es [4] = '{8'd194, 8'd128, 8'd246, 8'd127};
  logic       ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       en_s [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic       v_s [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    int lat1, lat2, lat8, cnt, last;
    logic [17:0] m;
    va[3] = 8'd128;

    m = model(8, 16'd10, 16'd13, 1'b0, 1'b0);
    check("model 10+13", m, 18'd23);
    m = model(8, 16'd200, 16'd250, 1'b0, 1'b0);
    check("model 200+250", m, {1'b0, 1'b1, 16'd194});
    m = model(8, 16'd128, 16'd1, 1'b0, 1'b1);
    check("model 128-1", m, {1'b1, 1'b1, 16'd127});

    @(posedge clk);
    #1;
    check("reset out_valid", v2, 0);
    check("reset s", s2, 0);
    check("reset cout", co2, 0);
    check("reset ovf", ov2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single transaction: value, one-cycle pulse, latency per configuration
    lat1 = 0; lat2 = 0; lat8 = 0;
    drive(1, 1, 8'd10, 8'd13, 0, 0);
    for (int e = 1; e <= 9; e++) begin
      if (v1 && lat1 == 0) lat1 = e;
      if (v2 && lat2 == 0) lat2 = e;
      if (v8 && lat8 == 0) lat8 = e;
      if (e == 1) check("s1 10+13", s1, 23);
      if (e == 2) begin
        check("s2 10+13", s2, 23);
        check("s2 10+13 cout", co2, 0);
        check("s2 10+13 ovf", ov2, 0);
      end
      if (e == 3) check("s2 single pulse", v2, 0);
      if (e == 8) check("s8 10+13", s8, 23);
      drive(1, 0, 8'd0, 8'd0, 0, 0);
    end
    check("latency s1", lat1, 1);
    check("latency s2", lat2, 2);
    check("latency s8", lat8, 8);

    // back-to-back add/sub corner vectors
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 1, va[i], vb[i], 0, vsb[i]);
      else drive(1, 0, 8'd0, 8'd0, 0, 0);
      if (i < 4) begin
        check("s1 vec s", s1, es[i]);
        check("s1 vec cout", co1, ec[i]);
        check("s1 vec ovf", ov1, eo[i]);
      end
      if (i >= 1) begin
        check("s2 vec s", s2, es[i-1]);
        check("s2 vec cout", co2, ec[i-1]);
        check("s2 vec ovf", ov2, eo[i-1]);
      end
    end
    repeat (8) drive(1, 0, 8'd0, 8'd0, 0, 0);

    // stream of 4 with a 3-cycle stall after the second
    cnt = 0; last = 0;
    for (int i = 0; i < 10; i++) begin
      drive(en_s[i], v_s[i], 8'(16 * i + 3), 8'(9 * i + 100), i[0], i[1]);
      if (v2) begin
        cnt++;
        last = i + 1;
      end
    end
    check("stall out_valid cycles", cnt, 7);
    check("stall last result edge", last, 8);
    repeat (8) drive(1, 0, 8'd0, 8'd0, 0, 0);

    // reset with transactions in flight; reset overrides en
    drive(1, 1, 8'd5, 8'd6, 0, 0);
    drive(1, 1, 8'd7, 8'd8, 0, 1);
    rst = 1'b1;
    #1;
    check("async rst out_valid s2", v2, 0);
    check("async rst s s2", s2, 0);
    check("async rst out_valid s8", v8, 0);
    check("async rst s s8", s8, 0);
    check("async rst out_valid s16", v16, 0);
    drive(1, 1, 8'd1, 8'd2, 0, 0);
    drive(1, 1, 8'd3, 8'd4, 0, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'd0, 8'd0, 0, 0);
      if (v1 || v2 || v8 || v16) cnt++;
    end
    check("no stale result after reset", cnt, 0);

    // random traffic, mixed add/sub and stalls
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      a = 8'($urandom); b = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
    repeat (10) drive(1, 0, 8'd0, 8'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
